// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event helpers for the PS/2 key sequencer.
// Events are packed as {ext, brk, code[7:0]}.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam int EVT_W       = 10;
  localparam int EVT_EXT_BIT = 9;
  localparam int EVT_BRK_BIT = 8;
  localparam int EVT_CODE_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  function automatic logic ps2_is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

  // Keyboard status/handshake bytes that never represent a key.
  function automatic logic ps2_is_housekeeping(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_PAUSE) ||
           (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

  function automatic logic [EVT_W-1:0] ps2_make_evt(input logic ext, input logic brk,
                                                    input logic [7:0] code);
    logic [EVT_W-1:0] e;
    e = {EVT_W{1'b0}};
    e[EVT_EXT_BIT] = ext;
    e[EVT_BRK_BIT] = brk;
    e[EVT_CODE_LO +: 8] = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Byte-receiver / CPU-side signal bundle of the key sequencer.
// The master side is the environment, the slave side is the sequencer.
interface ps2_key_sequencer_if #(
  parameter int DEPTH = 4
) ();
  logic                   rx_valid;
  logic [7:0]             rx_data;
  logic                   rx_err;
  logic                   evt_rd;
  logic                   evt_valid;
  logic [9:0]             evt_data;
  logic [$clog2(DEPTH):0] evt_count;
  logic                   overflow;
  logic                   ovf_clr;

  modport master (
    output rx_valid, rx_data, rx_err, evt_rd, ovf_clr,
    input  evt_valid, evt_data, evt_count, overflow
  );

  modport slave (
    input  rx_valid, rx_data, rx_err, evt_rd, ovf_clr,
    output evt_valid, evt_data, evt_count, overflow
  );
endinterface

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO with registered head, valid and count.
// The head register is loaded with next-cycle contents so outputs never glitch.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             valid_r;
  logic [WIDTH-1:0] head_r;

  logic             pop_s;
  logic             full_s;
  logic             push_s;
  logic [AW-1:0]    rd_next_s;
  logic [CW-1:0]    count_next_s;
  logic [WIDTH-1:0] head_next_s;

  // Accept/drop decisions and the next-cycle pointer, count and head.
  always_comb begin
    pop_s     = pop && (count_r != {CW{1'b0}});
    full_s    = (count_r == CW'(DEPTH));
    push_s    = push && (!full_s || pop_s);
    dropped   = push && !push_s;
    rd_next_s = pop_s ? (rd_ptr_r + {{(AW-1){1'b0}}, 1'b1}) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
    // A push landing in the slot that becomes head must bypass the array.
    if (count_next_s == {CW{1'b0}}) begin
      head_next_s = {WIDTH{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = push_data;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered show-ahead outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != {CW{1'b0}});
      head_r   <= head_next_s;
    end
  end

  assign head  = head_r;
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/ps2_key_sequencer.sv
// Folds PS/2 E0/F0 prefixes into single key events and queues them for the CPU.
// Holds the prefix FSM, the stale-prefix timeout and the sticky overflow flag.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst,
  ps2_key_sequencer_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  ps2_state_t        state_r;
  logic [TW-1:0]     tmo_cnt_r;
  logic              overflow_r;

  logic              rx_ok_s;
  logic              push_s;
  logic              ext_s;
  logic              brk_s;
  logic [EVT_W-1:0]  push_data_s;
  logic              dropped_s;
  logic [EVT_W-1:0]  head_s;
  logic              valid_s;
  logic [$clog2(DEPTH):0] count_s;

  // Decide whether the current byte completes an event and how it is flagged.
  always_comb begin
    rx_ok_s = bus.rx_valid && !bus.rx_err;
    push_s  = 1'b0;
    ext_s   = 1'b0;
    brk_s   = 1'b0;
    if (rx_ok_s) begin
      case (state_r)
        ST_IDLE: begin
          push_s = !ps2_is_prefix(bus.rx_data) && !ps2_is_housekeeping(bus.rx_data);
        end
        ST_EXT: begin
          push_s = !ps2_is_prefix(bus.rx_data);
          ext_s  = 1'b1;
        end
        ST_BRK: begin
          push_s = !ps2_is_prefix(bus.rx_data);
          brk_s  = 1'b1;
        end
        ST_EXT_BRK: begin
          push_s = !ps2_is_prefix(bus.rx_data);
          ext_s  = 1'b1;
          brk_s  = 1'b1;
        end
        default: begin
          push_s = 1'b0;
        end
      endcase
    end else begin
      push_s = 1'b0;
    end
    push_data_s = ps2_make_evt(ext_s, brk_s, bus.rx_data);
  end

  // Prefix FSM and timeout; any received byte restarts the timeout window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      tmo_cnt_r <= {TW{1'b0}};
    end else if (bus.rx_valid) begin
      tmo_cnt_r <= {TW{1'b0}};
      if (bus.rx_err) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.rx_data == PS2_EXT) begin
              state_r <= ST_EXT;
            end else if (bus.rx_data == PS2_BRK) begin
              state_r <= ST_BRK;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_EXT: begin
            if (bus.rx_data == PS2_BRK) begin
              state_r <= ST_EXT_BRK;
            end else if (bus.rx_data == PS2_EXT) begin
              state_r <= ST_EXT;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_BRK:     state_r <= ST_IDLE;
          ST_EXT_BRK: state_r <= ST_IDLE;
          default:    state_r <= ST_IDLE;
        endcase
      end
    end else if (state_r != ST_IDLE) begin
      if (tmo_cnt_r == TMO_LAST) begin
        state_r   <= ST_IDLE;
        tmo_cnt_r <= {TW{1'b0}};
      end else begin
        tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      end
    end else begin
      tmo_cnt_r <= {TW{1'b0}};
    end
  end

  // Sticky overflow; a fresh drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (dropped_s) begin
      overflow_r <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_r <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (bus.evt_rd),
    .head      (head_s),
    .valid     (valid_s),
    .count     (count_s),
    .dropped   (dropped_s)
  );

  assign bus.evt_valid = valid_s;
  assign bus.evt_data  = head_s;
  assign bus.evt_count = count_s;
  assign bus.overflow  = overflow_r;

endmodule
